// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port round-robin arbiter sharing one combinational ALU
module alu_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid_0,
  output logic             req_ready_0,
  input  logic [31:0]      req_a_0,
  input  logic [31:0]      req_b_0,
  input  logic [3:0]       req_op_0,
  input  logic             req_valid_1,
  output logic             req_ready_1,
  input  logic [31:0]      req_a_1,
  input  logic [31:0]      req_b_1,
  input  logic [3:0]       req_op_1,
  output logic             rsp_valid_0,
  input  logic             rsp_ready_0,
  output logic [31:0]      rsp_result_0,
  output logic             rsp_zero_0,
  output logic             rsp_valid_1,
  input  logic             rsp_ready_1,
  output logic [31:0]      rsp_result_1,
  output logic             rsp_zero_1,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_control,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  output logic [CNT_W-1:0] grant_cnt_0,
  output logic [CNT_W-1:0] grant_cnt_1
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             prio_q, prio_d;
  logic             rsp_valid_0_q, rsp_valid_0_d;
  logic             rsp_valid_1_q, rsp_valid_1_d;
  logic [31:0]      rsp_result_0_q, rsp_result_0_d;
  logic [31:0]      rsp_result_1_q, rsp_result_1_d;
  logic             rsp_zero_0_q, rsp_zero_0_d;
  logic             rsp_zero_1_q, rsp_zero_1_d;
  logic [CNT_W-1:0] cnt_0_q, cnt_0_d;
  logic [CNT_W-1:0] cnt_1_q, cnt_1_d;

  logic elig_0, elig_1;
  logic gnt_0, gnt_1;

  // A port competes when it has a request and its slot is free or draining this cycle.
  always_comb begin
    elig_0 = rst_n && req_valid_0 && (!rsp_valid_0_q || rsp_ready_0);
    elig_1 = rst_n && req_valid_1 && (!rsp_valid_1_q || rsp_ready_1);
    gnt_0  = elig_0 && (!elig_1 || !prio_q);
    gnt_1  = elig_1 && (!elig_0 ||  prio_q);
  end

  assign req_ready_0 = gnt_0;
  assign req_ready_1 = gnt_1;

  // Steer the granted port's operands onto the shared ALU; idle drive is all zeros.
  always_comb begin
    alu_a       = '0;
    alu_b       = '0;
    alu_control = '0;
    if (gnt_0) begin
      alu_a       = req_a_0;
      alu_b       = req_b_0;
      alu_control = req_op_0;
    end else if (gnt_1) begin
      alu_a       = req_a_1;
      alu_b       = req_b_1;
      alu_control = req_op_1;
    end
  end

  // Next state: priority rotation, response slots (load wins over drain), saturating counters.
  always_comb begin
    prio_d         = prio_q;
    rsp_valid_0_d  = rsp_valid_0_q;
    rsp_result_0_d = rsp_result_0_q;
    rsp_zero_0_d   = rsp_zero_0_q;
    rsp_valid_1_d  = rsp_valid_1_q;
    rsp_result_1_d = rsp_result_1_q;
    rsp_zero_1_d   = rsp_zero_1_q;
    cnt_0_d        = cnt_0_q;
    cnt_1_d        = cnt_1_q;

    if (gnt_0) begin
      prio_d = 1'b1;
    end else if (gnt_1) begin
      prio_d = 1'b0;
    end

    if (gnt_0) begin
      rsp_valid_0_d  = 1'b1;
      rsp_result_0_d = alu_result;
      rsp_zero_0_d   = alu_zero;
    end else if (rsp_valid_0_q && rsp_ready_0) begin
      rsp_valid_0_d = 1'b0;
    end

    if (gnt_1) begin
      rsp_valid_1_d  = 1'b1;
      rsp_result_1_d = alu_result;
      rsp_zero_1_d   = alu_zero;
    end else if (rsp_valid_1_q && rsp_ready_1) begin
      rsp_valid_1_d = 1'b0;
    end

    if (gnt_0 && (cnt_0_q != CNT_MAX)) begin
      cnt_0_d = cnt_0_q + CNT_ONE;
    end
    if (gnt_1 && (cnt_1_q != CNT_MAX)) begin
      cnt_1_d = cnt_1_q + CNT_ONE;
    end
  end

  // State registers with synchronous active-low reset discarding pending responses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q         <= 1'b0;
      rsp_valid_0_q  <= 1'b0;
      rsp_result_0_q <= '0;
      rsp_zero_0_q   <= 1'b0;
      rsp_valid_1_q  <= 1'b0;
      rsp_result_1_q <= '0;
      rsp_zero_1_q   <= 1'b0;
      cnt_0_q        <= '0;
      cnt_1_q        <= '0;
    end else begin
      prio_q         <= prio_d;
      rsp_valid_0_q  <= rsp_valid_0_d;
      rsp_result_0_q <= rsp_result_0_d;
      rsp_zero_0_q   <= rsp_zero_0_d;
      rsp_valid_1_q  <= rsp_valid_1_d;
      rsp_result_1_q <= rsp_result_1_d;
      rsp_zero_1_q   <= rsp_zero_1_d;
      cnt_0_q        <= cnt_0_d;
      cnt_1_q        <= cnt_1_d;
    end
  end

  assign rsp_valid_0  = rsp_valid_0_q;
  assign rsp_result_0 = rsp_result_0_q;
  assign rsp_zero_0   = rsp_zero_0_q;
  assign rsp_valid_1  = rsp_valid_1_q;
  assign rsp_result_1 = rsp_result_1_q;
  assign rsp_zero_1   = rsp_zero_1_q;
  assign grant_cnt_0  = cnt_0_q;
  assign grant_cnt_1  = cnt_1_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port round-robin arbiter that shares one combinational `alu` instance between two requesters, e.g. the execute stage and an address/branch helper. Each port issues operand/opcode requests over a valid/ready handshake. The arbiter drives the shared ALU for the granted port and registers the result and zero flag into a per-port response slot. Each slot is held until the requester accepts it. Saturating per-port grant counters support performance monitoring.

## Interface
- `CNT_W`, default 16: width of each saturating grant counter.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `req_valid_0` / `req_valid_1`  in  1  request present on port 0 / 1.
- `req_ready_0` / `req_ready_1`  out  1  request accepted this cycle (grant); combinational.
- `req_a_0` / `req_a_1`  in  32  operand A.
- `req_b_0` / `req_b_1`  in  32  operand B.
- `req_op_0` / `req_op_1`  in  4  ALU opcode: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR; any other value yields result 0.
- `rsp_valid_0` / `rsp_valid_1`  out  1  response slot holds a result.
- `rsp_ready_0` / `rsp_ready_1`  in  1  requester consumes the response.
- `rsp_result_0` / `rsp_result_1`  out  32  registered ALU result.
- `rsp_zero_0` / `rsp_zero_1`  out  1  registered ALU zero flag.
- `alu_a`, `alu_b`  out  32  operands driven to the shared ALU.
- `alu_control`  out  4  opcode driven to the shared ALU.
- `alu_result`  in  32  shared ALU result (combinational from `alu_a`, `alu_b`, `alu_control`).
- `alu_zero`  in  1  shared ALU zero flag.
- `grant_cnt_0` / `grant_cnt_1`  out  CNT_W  accepted-request count, saturating.

## Operation
- Eligibility: port k is eligible when `req_valid_k` = 1 and its slot can take a result. The slot can take a result when `rsp_valid_k` = 0, or when `rsp_valid_k && rsp_ready_k` in the same cycle.
- Grant: at most one grant per cycle.
  - Only one port eligible: that port is granted.
  - Both ports eligible: the port named by the priority bit `prio` is granted.
  - `req_ready_k` = 1 only for the granted port.
- Priority: `prio` resets to 0. After any grant to port k, `prio` <= the other port. `prio` is unchanged when there is no grant.
- ALU drive:
  - Grant cycle: `alu_a`, `alu_b`, `alu_control` = granted port's `req_a`, `req_b`, `req_op`.
  - No grant: drive 0, 0, 0000.
- Opcodes pass through unfiltered. Unsupported opcodes return result 0 with zero = 1, as the ALU produces.
- Response slot k, evaluated each edge:
  - Grant to k: `rsp_result_k` <= `alu_result`, `rsp_zero_k` <= `alu_zero`, `rsp_valid_k` <= 1.
  - Else, if `rsp_valid_k && rsp_ready_k`: `rsp_valid_k` <= 0. Data is held and not cleared.
  - Else: hold.
  - Drain and new grant in the same cycle: `rsp_valid_k` stays 1 and the slot loads the new data.
- While `rsp_valid_k` = 1 and `rsp_ready_k` = 0, `rsp_result_k` and `rsp_zero_k` are stable.
- Counters: `grant_cnt_k` increments by 1 on each grant to k and saturates at 2^CNT_W-1 with no wrap.

## Timing
- Reset, with `rst_n` sampled low at an edge:
  - `rsp_valid_*` = 0, `rsp_result_*` = 0, `rsp_zero_*` = 0.
  - `grant_cnt_*` = 0, `prio` = 0.
  - `req_ready_*` = 0 whenever `rst_n` = 0, combinationally.
  - `alu_*` outputs = 0 whenever `rst_n` = 0.
- Reset mid-operation: any pending response is discarded. A request presented during reset is not accepted and not counted.
- Latency: request accepted at edge N → `rsp_valid_k` = 1 with data after edge N.
- Throughput:
  - Aggregate: 1 op/cycle.
  - Single port with `rsp_ready` held 1: 1 op/cycle.
  - Both ports contending: alternate ports every cycle.
- Response backpressure stalls only its own port. The other port is unaffected.
- No combinational path exists from `rsp_ready_k` to `rsp_valid_k`. The only combinational paths are `rsp_ready_k`/`req_valid_*` → `req_ready_*` and the `alu_*` outputs.
- Requester obligation: `req_*` must stay stable while `req_valid` = 1 and `req_ready` = 0. The bench checks this; the arbiter does not.

## Test plan
- Single port: port 0 ADD a=5, b=3 with `rsp_ready_0` = 1 → `req_ready_0` = 1 in cycle N; in cycle N+1 `rsp_valid_0` = 1, result = 8, zero = 0; `grant_cnt_0` = 1.
- Contention after reset: both ports valid every cycle, port 0 SUB 7-7, port 1 OR 0xF0|0x0F → grants 0, 1, 0, 1…; port 0 result 0, zero 1; port 1 result 0xFF, zero 0.
- Backpressure: `rsp_ready_0` = 0 after the first port-0 response → `req_ready_0` = 0 and `rsp_result_0` held stable for 5 cycles while port 1 is granted every cycle. Raising `rsp_ready_0` gives port 0 a grant that same cycle, and its new data appears the next cycle with `rsp_valid_0` continuously 1.
- Unsupported opcode: port 1 op 1111, a=0xFFFFFFFF → `rsp_result_1` = 0, `rsp_zero_1` = 1.
- Reset mid-operation: `rst_n` = 0 for 1 cycle while `rsp_valid_1` = 1 and both requests are pending → after that edge all outputs are at reset values and `req_ready_*` = 0 during reset; the first grant after release goes to port 0.
- Saturation: with `CNT_W` = 2, issue 6 port-0 requests → `grant_cnt_0` sequence 1, 2, 3, 3, 3, 3.
